sub_sequencer: RTL and testbench

Nibble-serial arithmetic controller that time-shares one external 4-bit ripple add/subtract datapath (four full adders, B inverted for subtraction, carry-in 1 for two's complement) between two requesters. It accepts NIBBLES×4-bit operand pairs and drives the datapath one nibble per cycle, LSB first, chaining carry/borrow through a register. It returns the full-width result, carry-out and borrow to the requester that was granted. It sits between the ALU-level request logic and the shared 4-bit adder instance.

---
 rtl/sub_sequencer.sv | 176 +++++++++++++++++
 tb/tb_sub_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_sequencer.sv
// Nibble-serial add/subtract controller sharing one external 4-bit adder between two requesters.
// Latency: accept in cycle T, RUN for NIBBLES cycles, resp_valid from T+NIBBLES+1; optional SUBSEQ_OVERFLOW_EN adds resp_ovf.
// Backpressure: ready only in IDLE; result held in DONE until resp_ready, pending requests simply wait.
module sub_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_op,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_op,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic [4*NIBBLES-1:0]   resp_result,
    output logic                   resp_cout,
    output logic                   resp_borrow,
    output logic                   resp_ovf,
    output logic [3:0]             dp_a,
    output logic [3:0]             dp_b,
    output logic                   dp_cin,
    input  logic [3:0]             dp_sum,
    input  logic                   dp_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           grant;
    logic           accept;
    logic           last_nib;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_q;
    logic           op_q;
    logic           id_q;
    logic           carry_q;
    logic           last_served;
    logic [KW-1:0]  k;
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;

    assign a_nib    = a_q[{k, 2'b00} +: 4];
    assign b_nib    = b_q[{k, 2'b00} +: 4];
    assign last_nib = (k == K_LAST);
    assign accept   = (state == IDLE) && (grant ? req1_valid : req0_valid);

    // Arbiter: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_served;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept -> walk all nibbles -> hold result until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (last_nib)   state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs: handshakes in IDLE, datapath drive in RUN, registered result in DONE, zeros elsewhere.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        dp_a        = 4'h0;
        dp_b        = 4'h0;
        dp_cin      = 1'b0;
        resp_valid  = 1'b0;
        resp_id     = 1'b0;
        resp_result = '0;
        resp_cout   = 1'b0;
        resp_borrow = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
            end
            RUN: begin
                dp_a   = a_nib;
                dp_b   = op_q ? b_nib : ~b_nib;
                dp_cin = (k == '0) ? ~op_q : carry_q;
            end
            DONE: begin
                resp_valid  = 1'b1;
                resp_id     = id_q;
                resp_result = res_q;
                resp_cout   = carry_q;
                resp_borrow = ~op_q & ~carry_q;
            end
            default: ;
        endcase
    end

    // Operand capture on accept, then one result nibble and carry per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            carry_q     <= 1'b0;
            last_served <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            id_q        <= 1'b0;
            res_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q         <= grant ? req1_a  : req0_a;
                        b_q         <= grant ? req1_b  : req0_b;
                        op_q        <= grant ? req1_op : req0_op;
                        id_q        <= grant;
                        last_served <= grant;
                        k           <= '0;
                    end
                end
                RUN: begin
                    res_q[{k, 2'b00} +: 4] <= dp_sum;
                    carry_q                <= dp_cout;
                    k                      <= last_nib ? '0 : k + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SUBSEQ_OVERFLOW_EN
    logic sign_a_q;
    logic sign_b_q;

    // Sign of A and of the effective (possibly inverted) B, taken on the final nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (state == RUN && last_nib) begin
            sign_a_q <= a_q[W-1];
            sign_b_q <= dp_b[3];
        end
    end

    assign resp_ovf = (state == DONE) && (sign_a_q == sign_b_q) && (res_q[W-1] != sign_a_q);
`else
    assign resp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub_sequencer.sv
// Bench for sub_sequencer: directed cases, arbitration, stall, mid-run reset and random traffic.
// Reference model works on whole operands; the 4-bit adder is modelled behaviourally here.
// Build with SUBSEQ_OVERFLOW_EN defined to cover the overflow output.
module tb_sub_sequencer;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;
`ifdef SUBSEQ_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        bit           id;
        logic [W-1:0] result;
        bit           cout;
        bit           borrow;
        bit           ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_op = 1'b0, req1_op = 1'b0;
    logic         resp_valid, resp_ready = 1'b0, resp_id, resp_cout, resp_borrow, resp_ovf;
    logic [W-1:0] resp_result;
    logic [3:0]   dp_a, dp_b, dp_sum;
    logic         dp_cin, dp_cout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Shared 4-bit adder.
    assign {dp_cout, dp_sum} = 5'(dp_a) + 5'(dp_b) + 5'(dp_cin);

    sub_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
        .resp_cout(resp_cout), .resp_borrow(resp_borrow), .resp_ovf(resp_ovf),
        .dp_a(dp_a), .dp_b(dp_b), .dp_cin(dp_cin), .dp_sum(dp_sum), .dp_cout(dp_cout)
    );

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t compute(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
        exp_t e;
        logic [W:0] s;
        e.id = id;
        if (op) begin
            s        = {1'b0, a} + {1'b0, b};
            e.cout   = s[W];
            e.borrow = 1'b0;
            e.ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s        = {1'b0, a} - {1'b0, b};
            e.cout   = (a >= b);
            e.borrow = (a < b);
            e.ovf    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        e.result = s[W-1:0];
        if (!OVF_ON) e.ovf = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Reference model: tracks busy/last-served at transaction level and checks every cycle.
    exp_t         exp_q[$];
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    int           m_cyc = 0;
    int           m_acc = 0;
    logic [W-1:0] m_a, m_b;
    bit           m_op;

    always @(negedge clk) begin
        bit       e_r0, e_r1, e_rv;
        int       j;
        logic [3:0] na, nb;
        if (chk_en) begin
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            e_rv = m_busy && (m_cyc > m_acc + NIBBLES);
            check1("req0_ready", req0_ready, e_r0);
            check1("req1_ready", req1_ready, e_r1);
            check1("resp_valid", resp_valid, e_rv);
            if (e_rv && exp_q.size() > 0) begin
                check1("resp_id", resp_id, exp_q[0].id);
                checkw("resp_result", resp_result, exp_q[0].result);
                check1("resp_cout", resp_cout, exp_q[0].cout);
                check1("resp_borrow", resp_borrow, exp_q[0].borrow);
                check1("resp_ovf", resp_ovf, exp_q[0].ovf);
            end
            j = m_cyc - m_acc - 1;
            if (m_busy && j >= 0 && j < NIBBLES) begin
                na = m_a[4*j +: 4];
                nb = m_op ? m_b[4*j +: 4] : ~m_b[4*j +: 4];
                checkw("dp_a_run", W'(dp_a), W'(na));
                checkw("dp_b_run", W'(dp_b), W'(nb));
            end else begin
                checkw("dp_a_idle", W'(dp_a), '0);
                checkw("dp_b_idle", W'(dp_b), '0);
                check1("dp_cin_idle", dp_cin, 1'b0);
            end
            if (rst) begin
                m_busy = 1'b0;
                m_last = 1'b1;
                exp_q.delete();
            end else begin
                if (e_rv && resp_ready) begin
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                end
                if (e_r0 || e_r1) begin
                    m_a  = e_r1 ? req1_a  : req0_a;
                    m_b  = e_r1 ? req1_b  : req0_b;
                    m_op = e_r1 ? req1_op : req0_op;
                    exp_q.push_back(compute(e_r1, m_a, m_b, m_op));
                    m_busy = 1'b1;
                    m_acc  = m_cyc;
                    m_last = e_r1;
                end
            end
            m_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Single operation with resp_ready high; returns the response and cycles from accept to resp_valid.
    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit op,
                          output exp_t got, output int lat);
        int n;
        resp_ready = 1'b1;
        drive(id, 1'b1, a, b, op);
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("accept_in_time", n < 50, 1'b1);
        tick();
        drive(id, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got.id     = resp_id;
        got.result = resp_result;
        got.cout   = resp_cout;
        got.borrow = resp_borrow;
        got.ovf    = resp_ovf;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        exp_t got;
        int   lat;
        int   n;
        int   cnt0, cnt1;
        bit   acc0, acc1;
        int   order[$];
        logic [W-1:0] snap;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check1("rst_resp_valid", resp_valid, 1'b0);
        checkw("rst_resp_result", resp_result, '0);
        check1("rst_resp_id", resp_id, 1'b0);
        check1("rst_resp_cout", resp_cout, 1'b0);
        check1("rst_resp_borrow", resp_borrow, 1'b0);
        check1("rst_resp_ovf", resp_ovf, 1'b0);
        check1("rst_req0_ready", req0_ready, 1'b0);
        check1("rst_req1_ready", req1_ready, 1'b0);
        checkw("rst_dp_a", W'(dp_a), '0);
        check1("rst_dp_cin", dp_cin, 1'b0);

        // Both requesters valid continuously: grants must alternate starting with req0.
        tick();
        resp_ready = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        drive(0, 1'b1, rand_opnd(), rand_opnd(), 1'($urandom));
        drive(1, 1'b1, rand_opnd(), rand_opnd(), 1'($urandom));
        for (int c = 0; c < 200 && (cnt0 < 4 || cnt1 < 4); c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0) begin order.push_back(0); cnt0++; end
            if (acc1) begin order.push_back(1); cnt1++; end
            tick();
            if (acc0) drive(0, cnt0 < 4, rand_opnd(), rand_opnd(), 1'($urandom));
            if (acc1) drive(1, cnt1 < 4, rand_opnd(), rand_opnd(), 1'($urandom));
        end
        checkw("alt_count", W'(order.size()), W'(8));
        for (int i = 0; i < order.size() && i < 8; i++) checkw("alt_order", W'(order[i]), W'(i % 2));
        repeat (NIBBLES + 4) tick();
        resp_ready = 1'b0;

        // Directed arithmetic cases.
        run_op(0, 16'h1234, 16'h0235, 1'b0, got, lat);
        checkw("sub1_result", got.result, 16'h0FFF);
        check1("sub1_cout", got.cout, 1'b1);
        check1("sub1_borrow", got.borrow, 1'b0);
        check1("sub1_id", got.id, 1'b0);
        checkw("sub1_latency", W'(lat), W'(NIBBLES + 1));

        run_op(1, 16'h0001, 16'h0002, 1'b0, got, lat);
        checkw("sub2_result", got.result, 16'hFFFF);
        check1("sub2_borrow", got.borrow, 1'b1);
        check1("sub2_cout", got.cout, 1'b0);
        check1("sub2_id", got.id, 1'b1);

        run_op(1, 16'hFFFF, 16'h0001, 1'b1, got, lat);
        checkw("add_wrap_result", got.result, 16'h0000);
        check1("add_wrap_cout", got.cout, 1'b1);
        check1("add_wrap_borrow", got.borrow, 1'b0);

        run_op(0, 16'h8000, 16'h0001, 1'b0, got, lat);
        checkw("ovf_sub_result", got.result, 16'h7FFF);
        check1("ovf_sub_flag", got.ovf, OVF_ON);

        run_op(0, 16'h7FFF, 16'h0001, 1'b1, got, lat);
        checkw("ovf_add_result", got.result, 16'h8000);
        check1("ovf_add_flag", got.ovf, OVF_ON);

        // Stall in DONE for 10 cycles with req1 waiting.
        resp_ready = 1'b0;
        drive(0, 1'b1, 16'h00FF, 16'h0F0F, 1'b1);
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 50) begin @(negedge clk); n++; end
        check1("stall_accept", n < 50, 1'b1);
        tick();
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b1, 16'h0003, 16'h0001, 1'b0);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        checkw("stall_result", resp_result, 16'h100E);
        snap = resp_result;
        for (int i = 0; i < 10; i++) begin
            check1("stall_valid", resp_valid, 1'b1);
            checkw("stall_hold", resp_result, snap);
            check1("stall_id", resp_id, 1'b0);
            check1("stall_r0", req0_ready, 1'b0);
            check1("stall_r1", req1_ready, 1'b0);
            tick();
            @(negedge clk);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        check1("stall_hs_valid", resp_valid, 1'b1);
        tick();
        @(negedge clk);
        check1("stall_next_accept", req1_ready, 1'b1);
        tick();
        drive(1, 1'b0, '0, '0, 1'b0);
        repeat (NIBBLES + 3) tick();

        // Reset in the second RUN cycle discards the operation.
        drive(0, 1'b1, 16'hABCD, 16'h1111, 1'b1);
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 50) begin @(negedge clk); n++; end
        check1("rstrun_accept", n < 50, 1'b1);
        tick();
        drive(0, 1'b0, '0, '0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check1("rstrun_valid", resp_valid, 1'b0);
        checkw("rstrun_result", resp_result, '0);
        check1("rstrun_cout", resp_cout, 1'b0);
        check1("rstrun_borrow", resp_borrow, 1'b0);
        check1("rstrun_ovf", resp_ovf, 1'b0);
        check1("rstrun_id", resp_id, 1'b0);
        checkw("rstrun_dp_a", W'(dp_a), '0);
        checkw("rstrun_dp_b", W'(dp_b), '0);
        check1("rstrun_dp_cin", dp_cin, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check1("rstrun_no_resp", resp_valid, 1'b0);
            tick();
            @(negedge clk);
        end
        tick();
        run_op(1, 16'h5A5A, 16'h0A5B, 1'b0, got, lat);
        checkw("post_rst_result", got.result, 16'h4FFF);
        check1("post_rst_cout", got.cout, 1'b1);
        checkw("post_rst_latency", W'(lat), W'(NIBBLES + 1));

        // Random traffic with random response backpressure.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (acc0 || !req0_valid) drive(0, $urandom_range(0, 2) != 0, rand_opnd(), rand_opnd(), 1'($urandom));
            if (acc1 || !req1_valid) drive(1, $urandom_range(0, 2) != 0, rand_opnd(), rand_opnd(), 1'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        resp_ready = 1'b1;
        repeat (NIBBLES + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
